// File: rtl/uart_tx_arbiter.sv
// Round-robin AXI-Stream arbiter feeding the shared UART transmit FIFO.
// One source is granted at a time. The grant is held until the end of the
// packet (tlast), until the burst limit is reached, or until the granted
// source has been idle long enough to trigger the stall timeout.
// Every forwarded beat is tagged with the index of its source on tuser.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no grant; pick the next requester after last_grant
// XFER  | granted source passed straight through to the FIFO port
module uart_tx_arbiter #(
  parameter  int DATA_WIDTH    = 8,
  parameter  int NUM_SRC       = 4,
  parameter  int MAX_BURST     = 16,
  parameter  int STALL_TIMEOUT = 256,
  localparam int SW            = $clog2(NUM_SRC)
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_SRC-1:0]            s_axis_tvalid,
  input  logic [NUM_SRC-1:0]            s_axis_tlast,
  output logic [NUM_SRC-1:0]            s_axis_tready,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  output logic [SW-1:0]                 m_axis_tuser,
  output logic                          busy,
  output logic                          timeout_pulse
);

  localparam int BW = $clog2(MAX_BURST + 1);
  // Keep the stall counter at least one bit wide when the timeout is disabled.
  localparam int TW = (STALL_TIMEOUT > 0) ? $clog2(STALL_TIMEOUT + 1) : 1;

  localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);
  // Release happens on the idle cycle that would bring the count to
  // STALL_TIMEOUT, so exactly STALL_TIMEOUT idle cycles elapse in XFER.
  localparam logic [TW-1:0] STALL_LAST = TW'((STALL_TIMEOUT > 0) ? STALL_TIMEOUT - 1 : 0);
  localparam logic [SW-1:0] LAST_SRC   = SW'(NUM_SRC - 1);

  typedef enum logic {
    ST_IDLE,
    ST_XFER
  } state_t;

  state_t          state_q, state_d;
  logic [SW-1:0]   grant_q, grant_d;
  logic [SW-1:0]   last_grant_q, last_grant_d;
  logic [BW-1:0]   beat_cnt_q, beat_cnt_d;
  logic [TW-1:0]   stall_cnt_q, stall_cnt_d;

  logic            req_found;
  logic [SW-1:0]   req_sel;
  logic [SW-1:0]   cand;
  logic            hs;
  logic            timeout_hit;

  // Cyclic scan for the first valid requester, starting after last_grant.
  always_comb begin
    req_found = 1'b0;
    req_sel   = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      cand = SW'((int'(last_grant_q) + k) % NUM_SRC);
      if (!req_found && s_axis_tvalid[cand]) begin
        req_found = 1'b1;
        req_sel   = cand;
      end
    end
  end

  // Zero-latency passthrough of the granted source; everything is forced
  // quiet while reset is asserted so nothing is accepted mid-reset.
  always_comb begin
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tlast  = 1'b0;
    s_axis_tready = '0;
    if (aresetn && state_q == ST_XFER) begin
      m_axis_tvalid          = s_axis_tvalid[grant_q];
      m_axis_tdata           = s_axis_tdata[grant_q*DATA_WIDTH +: DATA_WIDTH];
      m_axis_tlast           = s_axis_tlast[grant_q];
      s_axis_tready[grant_q] = m_axis_tready;
    end
  end

  assign hs            = m_axis_tvalid & m_axis_tready;
  assign m_axis_tuser  = grant_q;
  assign busy          = (state_q == ST_XFER);
  assign timeout_pulse = aresetn & timeout_hit;

  // Next-state logic: arbitration, beat/stall counting and grant release.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    beat_cnt_d   = beat_cnt_q;
    stall_cnt_d  = stall_cnt_q;
    timeout_hit  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_found) begin
          grant_d     = req_sel;
          beat_cnt_d  = '0;
          stall_cnt_d = '0;
          state_d     = ST_XFER;
        end
      end
      ST_XFER: begin
        if (hs) begin
          beat_cnt_d  = beat_cnt_q + 1'b1;
          stall_cnt_d = '0;
          if (m_axis_tlast || beat_cnt_q == BURST_LAST) begin
            state_d      = ST_IDLE;
            last_grant_d = grant_q;
          end
        end else if (!s_axis_tvalid[grant_q]) begin
          // Only a silent source counts as stalled; a full FIFO does not.
          if (STALL_TIMEOUT != 0 && stall_cnt_q == STALL_LAST) begin
            state_d      = ST_IDLE;
            last_grant_d = grant_q;
            timeout_hit  = 1'b1;
          end else begin
            stall_cnt_d = stall_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and counter registers with synchronous active-low reset.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      last_grant_q <= LAST_SRC;
      beat_cnt_q   <= '0;
      stall_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      beat_cnt_q   <= beat_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: per-source stimulus queues, a
// per-source expected-beat scoreboard, and logs of grants, beat cycles and
// timeout pulses used for timing and ordering checks.
module tb_uart_tx_arbiter;

  localparam int DW = 8;
  localparam int NS = 4;
  localparam int MB = 16;
  localparam int ST = 8;
  localparam int SW = 2;

  logic             aclk = 1'b0;
  logic             aresetn;
  logic [NS*DW-1:0] s_tdata;
  logic [NS-1:0]    s_tvalid;
  logic [NS-1:0]    s_tlast;
  logic [NS-1:0]    s_tready;
  logic [DW-1:0]    m_tdata;
  logic             m_tvalid;
  logic             m_tready;
  logic             m_tlast;
  logic [SW-1:0]    m_tuser;
  logic             busy;
  logic             timeout_pulse;

  always #5 aclk = ~aclk;

  uart_tx_arbiter #(
    .DATA_WIDTH    (DW),
    .NUM_SRC       (NS),
    .MAX_BURST     (MB),
    .STALL_TIMEOUT (ST)
  ) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tlast  (s_tlast),
    .s_axis_tready (s_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .m_axis_tlast  (m_tlast),
    .m_axis_tuser  (m_tuser),
    .busy          (busy),
    .timeout_pulse (timeout_pulse)
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  beat_t src_q[NS][$];
  beat_t exp_q[NS][$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Requests from the main sequence, applied by the driver after each edge.
  logic          rst_req = 1'b0;
  logic          rdy_req = 1'b1;

  int rise_cyc[NS];
  int beat_cyc[$];
  int grant_log[$];
  int grant_beats[$];
  int pulse_cyc[$];
  int tst_beats = 0;

  logic mon_prev_busy = 1'b0;
  int   mon_user = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Source/sink driver: retire handshaken beats, present the next ones.
  initial begin
    logic [NS-1:0] hs;
    logic          prev_v;
    aresetn  = 1'b0;
    s_tvalid = '0;
    s_tdata  = '0;
    s_tlast  = '0;
    m_tready = 1'b1;
    forever begin
      @(negedge aclk);
      hs = s_tvalid & s_tready & {NS{aresetn}};
      @(posedge aclk);
      cyc++;
      #2;
      aresetn  = rst_req;
      m_tready = rdy_req;
      for (int i = 0; i < NS; i++) begin
        if (hs[i]) void'(src_q[i].pop_front());
        prev_v      = s_tvalid[i];
        s_tvalid[i] = (src_q[i].size() > 0);
        if (src_q[i].size() > 0) begin
          s_tdata[i*DW +: DW] = src_q[i][0].data;
          s_tlast[i]          = src_q[i][0].last;
        end else begin
          s_tdata[i*DW +: DW] = '0;
          s_tlast[i]          = 1'b0;
        end
        if (!prev_v && s_tvalid[i]) rise_cyc[i] = cyc;
      end
    end
  end

  // Monitor: log grants, pulses and beats; check beats against scoreboard.
  initial begin
    beat_t e;
    int    u;
    forever begin
      @(negedge aclk);
      if (timeout_pulse) pulse_cyc.push_back(cyc);
      if (busy && !mon_prev_busy) begin
        grant_log.push_back(int'(m_tuser));
        grant_beats.push_back(0);
        mon_user = int'(m_tuser);
      end
      if (aresetn && m_tvalid && m_tready) begin
        u = int'(m_tuser);
        beat_cyc.push_back(cyc);
        tst_beats++;
        if (grant_beats.size() > 0) grant_beats[grant_beats.size()-1]++;
        chk("tuser_stable", 32'(m_tuser), mon_user);
        chk("sb_nonempty", 32'(exp_q[u].size() > 0), 32'd1);
        if (exp_q[u].size() > 0) begin
          e = exp_q[u].pop_front();
          chk("sb_beat", 32'({m_tdata, m_tlast}), 32'({e.data, e.last}));
        end
      end
      mon_prev_busy = busy;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic nclk(input int n);
    repeat (n) begin
      @(negedge aclk);
      #1;
    end
  endtask

  task automatic push(input int s, input int n, input int base, input bit last_end);
    beat_t b;
    for (int k = 0; k < n; k++) begin
      b.data = DW'(base + k);
      b.last = last_end && (k == n - 1);
      src_q[s].push_back(b);
      exp_q[s].push_back(b);
    end
  endtask

  task automatic clear_logs();
    beat_cyc.delete();
    grant_log.delete();
    grant_beats.delete();
    pulse_cyc.delete();
    tst_beats = 0;
  endtask

  task automatic wait_drain(input string tag, input int budget, output int done_cyc);
    bit done = 0;
    done_cyc = -1;
    for (int t = 0; t < budget && !done; t++) begin
      nclk(1);
      if (src_q[0].size() == 0 && src_q[1].size() == 0 && src_q[2].size() == 0 &&
          src_q[3].size() == 0 && !busy) begin
        done     = 1;
        done_cyc = cyc;
      end
    end
    chk(tag, 32'(done), 32'd1);
  endtask

  task automatic wait_beats(input string tag, input int n, input int budget);
    bit done = 0;
    for (int t = 0; t < budget && !done; t++) begin
      nclk(1);
      if (tst_beats >= n) done = 1;
    end
    chk(tag, 32'(done), 32'd1);
  endtask

  initial begin
    int    dc;
    int    exp_rr[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    int    exp_bg[4] = '{2, 3, 2, 2};
    int    exp_bb[4] = '{16, 2, 16, 8};
    int    exp_rs[4] = '{1, 0, 1, 2};
    logic [DW-1:0] held;

    // Reset state
    nclk(4);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_mvalid", 32'(m_tvalid), 32'd0);
    chk("rst_tready", 32'(s_tready), 32'd0);
    chk("rst_tuser", 32'(m_tuser), 32'd0);
    chk("rst_pulse", 32'(timeout_pulse), 32'd0);

    // Single source, three bytes
    rst_req = 1'b1;
    nclk(3);
    clear_logs();
    push(1, 3, 'h41, 1'b1);
    wait_drain("single_drain", 50, dc);
    chk("single_beats", beat_cyc.size(), 3);
    chk("single_grant", (grant_log.size() > 0) ? grant_log[0] : -1, 1);
    if (beat_cyc.size() == 3) begin
      chk("single_latency", beat_cyc[0], rise_cyc[1] + 1);
      chk("single_b2", beat_cyc[1], beat_cyc[0] + 1);
      chk("single_b3", beat_cyc[2], beat_cyc[1] + 1);
      chk("single_busy_drop", dc, beat_cyc[2] + 1);
    end

    // Round-robin with one-byte packets on all sources
    rst_req = 1'b0;
    clear_logs();
    for (int s = 0; s < NS; s++) begin
      push(s, 1, 'h10 * s, 1'b1);
      push(s, 1, 'h10 * s + 1, 1'b1);
    end
    nclk(2);
    rst_req = 1'b1;
    wait_drain("rr_drain", 100, dc);
    chk("rr_grants", grant_log.size(), 8);
    for (int g = 0; g < 8 && g < grant_log.size(); g++)
      chk("rr_order", grant_log[g], exp_rr[g]);
    for (int g = 1; g < beat_cyc.size(); g++)
      chk("rr_gap", beat_cyc[g] - beat_cyc[g-1], 2);

    // Burst limit: 40-byte packet on src2 interleaved with src3
    rst_req = 1'b0;
    clear_logs();
    push(2, 40, 1, 1'b1);
    push(3, 2, 'hC0, 1'b1);
    nclk(2);
    rst_req = 1'b1;
    wait_drain("burst_drain", 200, dc);
    chk("burst_grants", grant_log.size(), 4);
    for (int g = 0; g < 4 && g < grant_log.size(); g++) begin
      chk("burst_order", grant_log[g], exp_bg[g]);
      chk("burst_len", grant_beats[g], exp_bb[g]);
    end

    // Stall timeout: src0 sends two beats then goes quiet
    rst_req = 1'b0;
    clear_logs();
    push(0, 2, 'h50, 1'b0);
    push(1, 1, 'h60, 1'b1);
    nclk(2);
    rst_req = 1'b1;
    wait_drain("stall_drain", 100, dc);
    chk("stall_pulses", pulse_cyc.size(), 1);
    if (pulse_cyc.size() > 0 && beat_cyc.size() > 1)
      chk("stall_pulse_cyc", pulse_cyc[0], beat_cyc[1] + ST);
    chk("stall_grants", grant_log.size(), 2);
    if (grant_log.size() > 1) begin
      chk("stall_g0_beats", grant_beats[0], 2);
      chk("stall_next_grant", grant_log[1], 1);
    end

    // Backpressure: FIFO full for over 20 cycles during src3's packet
    rst_req = 1'b0;
    clear_logs();
    push(3, 6, 'hA0, 1'b1);
    nclk(2);
    rst_req = 1'b1;
    wait_beats("bp_start", 2, 50);
    rdy_req = 1'b0;
    nclk(2);
    held = (exp_q[3].size() > 0) ? exp_q[3][0].data : '0;
    for (int t = 0; t < 20; t++) begin
      chk("bp_hold", 32'({s_tready[3], m_tvalid, m_tdata, timeout_pulse, busy}),
          32'({1'b0, 1'b1, held, 1'b0, 1'b1}));
      nclk(1);
    end
    rdy_req = 1'b1;
    wait_drain("bp_drain", 50, dc);
    chk("bp_no_timeout", pulse_cyc.size(), 0);
    chk("bp_one_grant", grant_log.size(), 1);
    chk("bp_beats", tst_beats, 6);

    // Reset in the middle of src1's packet
    rst_req = 1'b0;
    clear_logs();
    push(1, 8, 'h70, 1'b1);
    nclk(2);
    rst_req = 1'b1;
    wait_beats("rm_start", 4, 50);
    rst_req = 1'b0;
    push(0, 1, 'h30, 1'b1);
    push(2, 1, 'h90, 1'b1);
    nclk(1);
    chk("rm_tready_0", 32'(s_tready), 32'd0);
    chk("rm_mvalid_0", 32'(m_tvalid), 32'd0);
    nclk(1);
    chk("rm_tready_1", 32'(s_tready), 32'd0);
    chk("rm_mvalid_1", 32'(m_tvalid), 32'd0);
    chk("rm_idle", 32'(busy), 32'd0);
    rst_req = 1'b1;
    wait_drain("rm_drain", 100, dc);
    chk("rm_grants", grant_log.size(), 4);
    for (int g = 0; g < 4 && g < grant_log.size(); g++)
      chk("rm_order", grant_log[g], exp_rs[g]);

    for (int s = 0; s < NS; s++)
      chk("sb_empty", exp_q[s].size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
